cla_seq_adder: RTL and testbench

- Multi-cycle wide adder/subtractor controller that time-shares one 4-bit carry-lookahead slice across WIDTH/4 nibbles, least significant nibble first.
- Accepts one operation on a valid/ready input handshake and returns sum, carry-out and signed overflow on a valid/ready output handshake.
- Sits between an operand producer (ALU issue logic) and a result consumer.
- Trades latency for area against a full-width CLA.

---
 rtl/cla_seq_pkg.sv | 9 +
 rtl/cla_seq_adder_cla4_slice.sv | 20 ++
 rtl/cla_seq_adder.sv | 84 ++++++++
 tb/tb_cla_seq_adder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding and slice width for the sequential CLA adder
package cla_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/cla_seq_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead slice with flattened carries
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [3:0] g, p;
  logic       c1, c2;
  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s  = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: add/subtract by time-sharing one 4-bit CLA slice across WIDTH/4 nibbles
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic             carry, co, c3;
  logic [CW-1:0]    cnt;
  logic [3:0]       s;
  cla4_slice u_slice (
    .a (a_reg[NIBBLE_W-1:0]),
    .b (b_reg[NIBBLE_W-1:0]),
    .ci(carry),
    .s (s),
    .co(co),
    .c3(c3)
  );
  assign in_ready = (state == IDLE);
  assign acc_next = (acc >> NIBBLE_W) | (WIDTH'(s) << (WIDTH - NIBBLE_W));
  // Control FSM: capture operands, walk nibbles LSB first, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= op_sub ? ~b : b;
          carry <= op_sub ? ~cin : cin;
          cnt   <= '0;
          acc   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_reg <= a_reg >> NIBBLE_W;
          b_reg <= b_reg >> NIBBLE_W;
          carry <= co;
          acc   <= acc_next;
          if (cnt == CW'(NIB - 1)) begin
            sum       <= acc_next;
            cout      <= co;
            ovf       <= c3 ^ co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: table, hand-written and random checks of cla_seq_adder at WIDTH=16
module tb_cla_seq_adder;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  int compared = 0;
  int mismatched = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on signed/unsigned interpretations
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb);
    int unsigned u;
    int          sv;
    logic [W-1:0] r;
    logic co, ov;
    if (sb) begin
      u  = 32'(x) + 32'(1 << W) - 32'(y) - 32'(c);
      sv = int'($signed(x)) - int'($signed(y)) - int'(c);
    end else begin
      u  = 32'(x) + 32'(y) + 32'(c);
      sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    end
    r  = u[W-1:0];
    co = u[W];
    ov = (sv > 32767) || (sv < -32768);
    return {co, ov, r};
  endfunction

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int n;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; op_sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd4);
    chk({nm, " sum"}, 32'(sum), 32'(es));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
    chk({nm, " ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk);
    #1;
    chk({nm, " released"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vt[6];
  logic [W+1:0] m;
  logic [W-1:0] ra, rb;
  logic rc, rs;

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
             vt[i].s, vt[i].co, vt[i].ov);

    // Backpressure: result held while new requests are ignored
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 12 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d sum", i), 32'(sum), 32'h1011);
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    run_op("after bp", 16'h0123, 16'h0FFF, 1'b0, 1'b1, 16'hF124, 1'b0, 1'b0);

    // Reset during the second RUN cycle discards the operation
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst quiet%0d", i), 32'(out_valid), 32'd0);
    end
    run_op("after rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = rs ? ra : ~ra;
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, m[W-1:0], m[W+1], m[W]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
